// File: rtl/ysyx_24080006_pkg.sv
// Shared AXI channel structs plus the arbiter's state and grant encodings.
// The arbiter RTL and its bench both import this package.
package ysyx_24080006_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic              arready;
    logic              rvalid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
  } axi_r_s2m_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                wvalid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                bready;
  } axi_w_m2s_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic       bvalid;
    logic [1:0] bresp;
  } axi_w_s2m_t;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_arb_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} wr_arb_state_e;
  typedef enum logic {GNT_IFU, GNT_LSU} grant_e;

endpackage

// File: rtl/npc_arb_rr2.sv
// Two-input picker for the read port. On a tie it alternates against
// last_grant, or always favours the LSU when RR_EN is 0.
module npc_arb_rr2
  import ysyx_24080006_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   req_ifu,
  input  logic   req_lsu,
  input  logic   update,
  input  grant_e update_grant,
  output grant_e pick
);

  grant_e last_grant;

  // Starting at LSU means the IFU wins the first tie after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GNT_LSU;
    end else if (update) begin
      last_grant <= update_grant;
    end
  end

  always_comb begin
    pick = GNT_LSU;
    if (req_ifu && !req_lsu) begin
      pick = GNT_IFU;
    end else if (req_ifu && req_lsu && RR_EN && (last_grant == GNT_LSU)) begin
      pick = GNT_IFU;
    end
  end

endmodule

// File: rtl/npc_arbiter.sv
// Merges IFU reads and LSU reads/writes onto one AXI master. Address beats
// are latched and held on imd so the crossbar can route R/B by address.
module npc_arbiter
  import ysyx_24080006_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  axi_r_m2s_t ifu_r_m2s,
  output axi_r_s2m_t ifu_r_s2m,
  input  axi_r_m2s_t lsu_r_m2s,
  output axi_r_s2m_t lsu_r_s2m,
  input  axi_w_m2s_t lsu_w_m2s,
  output axi_w_s2m_t lsu_w_s2m,
  output axi_r_m2s_t imd_r_m2s,
  input  axi_r_s2m_t imd_r_s2m,
  output axi_w_m2s_t imd_w_m2s,
  input  axi_w_s2m_t imd_w_s2m
);

  rd_arb_state_e     rd_state;
  wr_arb_state_e     wr_state;
  grant_e            grant;
  grant_e            pick;
  axi_r_m2s_t        ar_sel;
  logic              ar_req;
  logic              r_done;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;

  assign ar_req = ifu_r_m2s.arvalid | lsu_r_m2s.arvalid;
  assign ar_sel = (pick == GNT_LSU) ? lsu_r_m2s : ifu_r_m2s;
  assign r_done = (rd_state == R_R) && imd_r_s2m.rvalid && imd_r_m2s.rready
                  && imd_r_s2m.rlast;

  npc_arb_rr2 #(
    .RR_EN(RR_EN)
  ) u_rr2 (
    .clock       (clock),
    .reset       (reset),
    .req_ifu     (ifu_r_m2s.arvalid),
    .req_lsu     (lsu_r_m2s.arvalid),
    .update      (r_done),
    .update_grant(grant),
    .pick        (pick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= R_IDLE;
      grant    <= GNT_IFU;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (ar_req) begin
          grant    <= pick;
          ar_addr  <= ar_sel.araddr;
          ar_len   <= ar_sel.arlen;
          ar_size  <= ar_sel.arsize;
          ar_burst <= ar_sel.arburst;
          rd_state <= R_AR;
        end
        R_AR:    if (imd_r_s2m.arready) rd_state <= R_R;
        R_R:     if (r_done) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // R data fans out to both masters; only rvalid selects the owner.
  always_comb begin
    ifu_r_s2m         = '0;
    lsu_r_s2m         = '0;
    imd_r_m2s         = '0;
    imd_r_m2s.araddr  = ar_addr;
    imd_r_m2s.arlen   = ar_len;
    imd_r_m2s.arsize  = ar_size;
    imd_r_m2s.arburst = ar_burst;
    imd_r_m2s.arvalid = (rd_state == R_AR);
    ifu_r_s2m.rresp   = imd_r_s2m.rresp;
    ifu_r_s2m.rdata   = imd_r_s2m.rdata;
    ifu_r_s2m.rlast   = imd_r_s2m.rlast;
    lsu_r_s2m.rresp   = imd_r_s2m.rresp;
    lsu_r_s2m.rdata   = imd_r_s2m.rdata;
    lsu_r_s2m.rlast   = imd_r_s2m.rlast;
    if ((rd_state == R_IDLE) && ar_req) begin
      if (pick == GNT_LSU) lsu_r_s2m.arready = 1'b1;
      else                 ifu_r_s2m.arready = 1'b1;
    end
    if (rd_state == R_R) begin
      if (grant == GNT_LSU) begin
        imd_r_m2s.rready = lsu_r_m2s.rready;
        lsu_r_s2m.rvalid = imd_r_s2m.rvalid;
      end else begin
        imd_r_m2s.rready = ifu_r_m2s.rready;
        ifu_r_s2m.rvalid = imd_r_s2m.rvalid;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= W_IDLE;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
    end else begin
      case (wr_state)
        W_IDLE: if (lsu_w_m2s.awvalid) begin
          aw_addr  <= lsu_w_m2s.awaddr;
          aw_len   <= lsu_w_m2s.awlen;
          aw_size  <= lsu_w_m2s.awsize;
          aw_burst <= lsu_w_m2s.awburst;
          wr_state <= W_AW;
        end
        W_AW: if (imd_w_s2m.awready) wr_state <= W_W;
        W_W:  if (lsu_w_m2s.wvalid && imd_w_s2m.wready && lsu_w_m2s.wlast) wr_state <= W_B;
        W_B:  if (imd_w_s2m.bvalid && lsu_w_m2s.bready) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // W is blocked outside W_W so early LSU data never reaches the crossbar.
  always_comb begin
    lsu_w_s2m         = '0;
    imd_w_m2s         = '0;
    imd_w_m2s.awaddr  = aw_addr;
    imd_w_m2s.awlen   = aw_len;
    imd_w_m2s.awsize  = aw_size;
    imd_w_m2s.awburst = aw_burst;
    imd_w_m2s.awvalid = (wr_state == W_AW);
    lsu_w_s2m.awready = (wr_state == W_IDLE);
    if (wr_state == W_W) begin
      imd_w_m2s.wvalid  = lsu_w_m2s.wvalid;
      imd_w_m2s.wdata   = lsu_w_m2s.wdata;
      imd_w_m2s.wstrb   = lsu_w_m2s.wstrb;
      imd_w_m2s.wlast   = lsu_w_m2s.wlast;
      lsu_w_s2m.wready  = imd_w_s2m.wready;
    end
    if (wr_state == W_B) begin
      imd_w_m2s.bready  = lsu_w_m2s.bready;
      lsu_w_s2m.bvalid  = imd_w_s2m.bvalid;
      lsu_w_s2m.bresp   = imd_w_s2m.bresp;
    end
  end

endmodule

// File: tb/tb_npc_arbiter.sv
// Directed bench for npc_arbiter: instance a uses round-robin reads,
// instance b has RR_EN=0 so the LSU wins every read tie.
module tb_npc_arbiter;
  import ysyx_24080006_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  axi_r_m2s_t ifu_rm, lsu_rm, imd_rm, ifu_rm_b, lsu_rm_b, imd_rm_b;
  axi_r_s2m_t ifu_rs, lsu_rs, imd_rs, ifu_rs_b, lsu_rs_b, imd_rs_b;
  axi_w_m2s_t lsu_wm, imd_wm, lsu_wm_b, imd_wm_b;
  axi_w_s2m_t lsu_ws, imd_ws, lsu_ws_b, imd_ws_b;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clock = ~clock;

  npc_arbiter #(.RR_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset),
    .ifu_r_m2s(ifu_rm), .ifu_r_s2m(ifu_rs),
    .lsu_r_m2s(lsu_rm), .lsu_r_s2m(lsu_rs),
    .lsu_w_m2s(lsu_wm), .lsu_w_s2m(lsu_ws),
    .imd_r_m2s(imd_rm), .imd_r_s2m(imd_rs),
    .imd_w_m2s(imd_wm), .imd_w_s2m(imd_ws)
  );

  npc_arbiter #(.RR_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .ifu_r_m2s(ifu_rm_b), .ifu_r_s2m(ifu_rs_b),
    .lsu_r_m2s(lsu_rm_b), .lsu_r_s2m(lsu_rs_b),
    .lsu_w_m2s(lsu_wm_b), .lsu_w_s2m(lsu_ws_b),
    .imd_r_m2s(imd_rm_b), .imd_r_s2m(imd_rs_b),
    .imd_w_m2s(imd_wm_b), .imd_w_s2m(imd_ws_b)
  );

  task automatic do_reset();
    reset = 1'b1;
    ifu_rm = '0; lsu_rm = '0; lsu_wm = '0; imd_rs = '0; imd_ws = '0;
    ifu_rm_b = '0; lsu_rm_b = '0; lsu_wm_b = '0; imd_rs_b = '0; imd_ws_b = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (imd_rm.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_imd_arvalid: got %0h want 0", imd_rm.arvalid); end
    n_checks++; if (imd_rm.rready !== 1'b0) begin n_fail++; $display("FAIL rst_imd_rready: got %0h want 0", imd_rm.rready); end
    n_checks++; if (ifu_rs.arready !== 1'b0) begin n_fail++; $display("FAIL rst_ifu_arready: got %0h want 0", ifu_rs.arready); end
    n_checks++; if (lsu_rs.rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_rvalid: got %0h want 0", lsu_rs.rvalid); end
    n_checks++; if (imd_wm.awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_imd_awvalid: got %0h want 0", imd_wm.awvalid); end
    n_checks++; if (imd_wm.wvalid !== 1'b0) begin n_fail++; $display("FAIL rst_imd_wvalid: got %0h want 0", imd_wm.wvalid); end
    n_checks++; if (imd_wm.bready !== 1'b0) begin n_fail++; $display("FAIL rst_imd_bready: got %0h want 0", imd_wm.bready); end
    n_checks++; if (lsu_ws.awready !== 1'b1) begin n_fail++; $display("FAIL rst_lsu_awready: got %0h want 1", lsu_ws.awready); end
    n_checks++; if (lsu_ws.wready !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_wready: got %0h want 0", lsu_ws.wready); end
    n_checks++; if (lsu_ws.bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_bvalid: got %0h want 0", lsu_ws.bvalid); end
    n_checks++; if (imd_rm.araddr !== 32'h0) begin n_fail++; $display("FAIL rst_araddr: got %h want 0", imd_rm.araddr); end
    n_checks++; if (imd_wm.awaddr !== 32'h0) begin n_fail++; $display("FAIL rst_awaddr: got %h want 0", imd_wm.awaddr); end
    n_checks++; if (imd_rm_b.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_b_arvalid: got %0h want 0", imd_rm_b.arvalid); end
  endtask

  task automatic test_ifu_read();
    @(negedge clock);
    ifu_rm.araddr = 32'h8000_0000; ifu_rm.arlen = 8'd0; ifu_rm.arsize = 3'd2;
    ifu_rm.arburst = 2'b01; ifu_rm.arvalid = 1'b1; ifu_rm.rready = 1'b1;
    #1;
    n_checks++; if (ifu_rs.arready !== 1'b1) begin n_fail++; $display("FAIL ifu_arready: got %0h want 1", ifu_rs.arready); end
    n_checks++; if (lsu_rs.arready !== 1'b0) begin n_fail++; $display("FAIL ifu_lsu_arready: got %0h want 0", lsu_rs.arready); end
    n_checks++; if (imd_rm.arvalid !== 1'b0) begin n_fail++; $display("FAIL ifu_arvalid_early: got %0h want 0", imd_rm.arvalid); end
    @(negedge clock);
    ifu_rm.arvalid = 1'b0; imd_rs.arready = 1'b1;
    #1;
    n_checks++; if (imd_rm.arvalid !== 1'b1) begin n_fail++; $display("FAIL ifu_imd_arvalid: got %0h want 1", imd_rm.arvalid); end
    n_checks++; if (imd_rm.araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL ifu_araddr_ar: got %h want 80000000", imd_rm.araddr); end
    n_checks++; if (imd_rm.arsize !== 3'd2) begin n_fail++; $display("FAIL ifu_arsize: got %0h want 2", imd_rm.arsize); end
    n_checks++; if (ifu_rs.arready !== 1'b0) begin n_fail++; $display("FAIL ifu_arready_in_ar: got %0h want 0", ifu_rs.arready); end
    @(negedge clock);
    imd_rs.arready = 1'b0; imd_rs.rvalid = 1'b1; imd_rs.rdata = 32'hDEAD_BEEF; imd_rs.rlast = 1'b1;
    #1;
    n_checks++; if (imd_rm.arvalid !== 1'b0) begin n_fail++; $display("FAIL ifu_arvalid_in_r: got %0h want 0", imd_rm.arvalid); end
    n_checks++; if (ifu_rs.rvalid !== 1'b1) begin n_fail++; $display("FAIL ifu_rvalid: got %0h want 1", ifu_rs.rvalid); end
    n_checks++; if (ifu_rs.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ifu_rdata: got %h want deadbeef", ifu_rs.rdata); end
    n_checks++; if (lsu_rs.rvalid !== 1'b0) begin n_fail++; $display("FAIL ifu_lsu_rvalid: got %0h want 0", lsu_rs.rvalid); end
    n_checks++; if (imd_rm.rready !== 1'b1) begin n_fail++; $display("FAIL ifu_imd_rready: got %0h want 1", imd_rm.rready); end
    n_checks++; if (imd_rm.araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL ifu_araddr_r: got %h want 80000000", imd_rm.araddr); end
    @(negedge clock);
    imd_rs.rvalid = 1'b0; imd_rs.rlast = 1'b0;
    #1;
    n_checks++; if (ifu_rs.rvalid !== 1'b0) begin n_fail++; $display("FAIL ifu_rvalid_idle: got %0h want 0", ifu_rs.rvalid); end
    n_checks++; if (imd_rm.araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL ifu_araddr_idle: got %h want 80000000", imd_rm.araddr); end
  endtask

  task automatic test_lsu_write();
    @(negedge clock);
    lsu_wm.awaddr = 32'h0200_0000; lsu_wm.awlen = 8'd1; lsu_wm.awsize = 3'd2; lsu_wm.awburst = 2'b01;
    lsu_wm.awvalid = 1'b1; lsu_wm.wvalid = 1'b1; lsu_wm.wdata = 32'hA5A5_0000;
    lsu_wm.wstrb = 4'hF; lsu_wm.wlast = 1'b0; lsu_wm.bready = 1'b0; imd_ws.wready = 1'b1;
    #1;
    n_checks++; if (lsu_ws.awready !== 1'b1) begin n_fail++; $display("FAIL wr_awready: got %0h want 1", lsu_ws.awready); end
    n_checks++; if (lsu_ws.wready !== 1'b0) begin n_fail++; $display("FAIL wr_wready_idle: got %0h want 0", lsu_ws.wready); end
    n_checks++; if (imd_wm.wvalid !== 1'b0) begin n_fail++; $display("FAIL wr_wvalid_idle: got %0h want 0", imd_wm.wvalid); end
    @(negedge clock);
    lsu_wm.awvalid = 1'b0; imd_ws.awready = 1'b1;
    #1;
    n_checks++; if (imd_wm.awvalid !== 1'b1) begin n_fail++; $display("FAIL wr_imd_awvalid: got %0h want 1", imd_wm.awvalid); end
    n_checks++; if (imd_wm.awaddr !== 32'h0200_0000) begin n_fail++; $display("FAIL wr_awaddr_aw: got %h want 02000000", imd_wm.awaddr); end
    n_checks++; if (lsu_ws.wready !== 1'b0) begin n_fail++; $display("FAIL wr_wready_aw: got %0h want 0", lsu_ws.wready); end
    n_checks++; if (imd_wm.wvalid !== 1'b0) begin n_fail++; $display("FAIL wr_wvalid_aw: got %0h want 0", imd_wm.wvalid); end
    n_checks++; if (lsu_ws.awready !== 1'b0) begin n_fail++; $display("FAIL wr_awready_aw: got %0h want 0", lsu_ws.awready); end
    @(negedge clock);
    imd_ws.awready = 1'b0;
    #1;
    n_checks++; if (imd_wm.wvalid !== 1'b1) begin n_fail++; $display("FAIL wr_wvalid_w: got %0h want 1", imd_wm.wvalid); end
    n_checks++; if (imd_wm.wdata !== 32'hA5A5_0000) begin n_fail++; $display("FAIL wr_wdata0: got %h want a5a50000", imd_wm.wdata); end
    n_checks++; if (lsu_ws.wready !== 1'b1) begin n_fail++; $display("FAIL wr_wready_w: got %0h want 1", lsu_ws.wready); end
    n_checks++; if (imd_wm.awvalid !== 1'b0) begin n_fail++; $display("FAIL wr_awvalid_w: got %0h want 0", imd_wm.awvalid); end
    @(negedge clock);
    lsu_wm.wdata = 32'hA5A5_0001; lsu_wm.wlast = 1'b1;
    #1;
    n_checks++; if (imd_wm.wdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_wdata1: got %h want a5a50001", imd_wm.wdata); end
    n_checks++; if (imd_wm.wlast !== 1'b1) begin n_fail++; $display("FAIL wr_wlast: got %0h want 1", imd_wm.wlast); end
    @(negedge clock);
    lsu_wm.wvalid = 1'b0; lsu_wm.wlast = 1'b0; imd_ws.bvalid = 1'b1;
    #1;
    n_checks++; if (lsu_ws.bvalid !== 1'b1) begin n_fail++; $display("FAIL wr_lsu_bvalid: got %0h want 1", lsu_ws.bvalid); end
    n_checks++; if (imd_wm.bready !== 1'b0) begin n_fail++; $display("FAIL wr_bready_low: got %0h want 0", imd_wm.bready); end
    n_checks++; if (lsu_ws.wready !== 1'b0) begin n_fail++; $display("FAIL wr_wready_b: got %0h want 0", lsu_ws.wready); end
    @(negedge clock);
    lsu_wm.bready = 1'b1;
    #1;
    n_checks++; if (imd_wm.bready !== 1'b1) begin n_fail++; $display("FAIL wr_bready_high: got %0h want 1", imd_wm.bready); end
    n_checks++; if (imd_wm.awaddr !== 32'h0200_0000) begin n_fail++; $display("FAIL wr_awaddr_b: got %h want 02000000", imd_wm.awaddr); end
    @(negedge clock);
    imd_ws.bvalid = 1'b0; lsu_wm.bready = 1'b0; imd_ws.wready = 1'b0;
    #1;
    n_checks++; if (lsu_ws.awready !== 1'b1) begin n_fail++; $display("FAIL wr_awready_back: got %0h want 1", lsu_ws.awready); end
    n_checks++; if (lsu_ws.bvalid !== 1'b0) begin n_fail++; $display("FAIL wr_bvalid_idle: got %0h want 0", lsu_ws.bvalid); end
  endtask

  task automatic test_burst();
    int beat;
    @(negedge clock);
    ifu_rm.araddr = 32'h8000_0100; ifu_rm.arlen = 8'd3; ifu_rm.arvalid = 1'b1; ifu_rm.rready = 1'b0;
    #1;
    n_checks++; if (ifu_rs.arready !== 1'b1) begin n_fail++; $display("FAIL burst_arready: got %0h want 1", ifu_rs.arready); end
    @(negedge clock);
    ifu_rm.arvalid = 1'b0; imd_rs.arready = 1'b1;
    #1;
    n_checks++; if (imd_rm.arlen !== 8'd3) begin n_fail++; $display("FAIL burst_arlen: got %0h want 3", imd_rm.arlen); end
    @(negedge clock);
    imd_rs.arready = 1'b0;
    beat = 0;
    for (int cyc = 0; cyc < 16 && beat < 4; cyc++) begin
      if (cyc != 0) @(negedge clock);
      ifu_rm.rready = cyc[0];
      imd_rs.rvalid = 1'b1; imd_rs.rdata = 32'hB000_0000 + beat; imd_rs.rlast = (beat == 3);
      #1;
      n_checks++; if (ifu_rs.rvalid !== 1'b1) begin n_fail++; $display("FAIL burst_rvalid: got %0h want 1 beat %0d", ifu_rs.rvalid, beat); end
      n_checks++; if (ifu_rs.rdata !== 32'hB000_0000 + beat) begin n_fail++; $display("FAIL burst_rdata: got %h want %h", ifu_rs.rdata, 32'hB000_0000 + beat); end
      n_checks++; if (ifu_rs.rlast !== (beat == 3)) begin n_fail++; $display("FAIL burst_rlast: got %0h beat %0d", ifu_rs.rlast, beat); end
      n_checks++; if (imd_rm.rready !== ifu_rm.rready) begin n_fail++; $display("FAIL burst_rready: got %0h want %0h", imd_rm.rready, ifu_rm.rready); end
      if (ifu_rm.rready) beat++;
    end
    n_checks++; if (beat != 4) begin n_fail++; $display("FAIL burst_beats: got %0d want 4", beat); end
    @(negedge clock);
    imd_rs.rdata = 32'hB000_00FF; imd_rs.rlast = 1'b0; ifu_rm.rready = 1'b1;
    #1;
    n_checks++; if (ifu_rs.rvalid !== 1'b0) begin n_fail++; $display("FAIL burst_idle_rvalid: got %0h want 0", ifu_rs.rvalid); end
    n_checks++; if (imd_rm.rready !== 1'b0) begin n_fail++; $display("FAIL burst_idle_rready: got %0h want 0", imd_rm.rready); end
    imd_rs.rvalid = 1'b0;
  endtask

  task automatic test_rr_tie();
    do_reset();
    @(negedge clock);
    ifu_rm.araddr = 32'h8000_0010; ifu_rm.arvalid = 1'b1; ifu_rm.rready = 1'b1;
    lsu_rm.araddr = 32'h1000_0000; lsu_rm.arvalid = 1'b1; lsu_rm.rready = 1'b1;
    #1;
    n_checks++; if (ifu_rs.arready !== 1'b1) begin n_fail++; $display("FAIL rr1_ifu_arready: got %0h want 1", ifu_rs.arready); end
    n_checks++; if (lsu_rs.arready !== 1'b0) begin n_fail++; $display("FAIL rr1_lsu_arready: got %0h want 0", lsu_rs.arready); end
    @(negedge clock);
    ifu_rm.arvalid = 1'b0; imd_rs.arready = 1'b1;
    #1;
    n_checks++; if (imd_rm.araddr !== 32'h8000_0010) begin n_fail++; $display("FAIL rr1_araddr: got %h want 80000010", imd_rm.araddr); end
    n_checks++; if (lsu_rs.arready !== 1'b0) begin n_fail++; $display("FAIL rr1_lsu_wait: got %0h want 0", lsu_rs.arready); end
    @(negedge clock);
    imd_rs.arready = 1'b0; imd_rs.rvalid = 1'b1; imd_rs.rdata = 32'h1111_0001; imd_rs.rlast = 1'b1;
    #1;
    n_checks++; if (ifu_rs.rdata !== 32'h1111_0001 || ifu_rs.rvalid !== 1'b1) begin n_fail++; $display("FAIL rr1_ifu_data: got %h/%0h want 11110001/1", ifu_rs.rdata, ifu_rs.rvalid); end
    n_checks++; if (lsu_rs.rvalid !== 1'b0) begin n_fail++; $display("FAIL rr1_lsu_rvalid: got %0h want 0", lsu_rs.rvalid); end
    @(negedge clock);
    imd_rs.rvalid = 1'b0; imd_rs.rlast = 1'b0;
    ifu_rm.araddr = 32'h8000_0020; ifu_rm.arvalid = 1'b1;
    #1;
    n_checks++; if (lsu_rs.arready !== 1'b1) begin n_fail++; $display("FAIL rr2_lsu_arready: got %0h want 1", lsu_rs.arready); end
    n_checks++; if (ifu_rs.arready !== 1'b0) begin n_fail++; $display("FAIL rr2_ifu_arready: got %0h want 0", ifu_rs.arready); end
    @(negedge clock);
    lsu_rm.arvalid = 1'b0; imd_rs.arready = 1'b1;
    #1;
    n_checks++; if (imd_rm.araddr !== 32'h1000_0000) begin n_fail++; $display("FAIL rr2_araddr: got %h want 10000000", imd_rm.araddr); end
    @(negedge clock);
    imd_rs.arready = 1'b0; imd_rs.rvalid = 1'b1; imd_rs.rdata = 32'h2222_0002; imd_rs.rlast = 1'b1;
    #1;
    n_checks++; if (lsu_rs.rdata !== 32'h2222_0002 || lsu_rs.rvalid !== 1'b1) begin n_fail++; $display("FAIL rr2_lsu_data: got %h/%0h want 22220002/1", lsu_rs.rdata, lsu_rs.rvalid); end
    n_checks++; if (ifu_rs.rvalid !== 1'b0) begin n_fail++; $display("FAIL rr2_ifu_rvalid: got %0h want 0", ifu_rs.rvalid); end
    @(negedge clock);
    imd_rs.rvalid = 1'b0; imd_rs.rlast = 1'b0;
    #1;
    n_checks++; if (ifu_rs.arready !== 1'b1) begin n_fail++; $display("FAIL rr3_ifu_arready: got %0h want 1", ifu_rs.arready); end
    @(negedge clock);
    ifu_rm.arvalid = 1'b0; imd_rs.arready = 1'b1;
    #1;
    n_checks++; if (imd_rm.araddr !== 32'h8000_0020) begin n_fail++; $display("FAIL rr3_araddr: got %h want 80000020", imd_rm.araddr); end
    @(negedge clock);
    imd_rs.arready = 1'b0; imd_rs.rvalid = 1'b1; imd_rs.rdata = 32'h3333_0003; imd_rs.rlast = 1'b1;
    #1;
    n_checks++; if (ifu_rs.rdata !== 32'h3333_0003 || ifu_rs.rvalid !== 1'b1) begin n_fail++; $display("FAIL rr3_ifu_data: got %h/%0h want 33330003/1", ifu_rs.rdata, ifu_rs.rvalid); end
    @(negedge clock);
    imd_rs.rvalid = 1'b0; imd_rs.rlast = 1'b0;
  endtask

  task automatic test_rr_fixed();
    do_reset();
    @(negedge clock);
    ifu_rm_b.araddr = 32'h8000_0010; ifu_rm_b.arvalid = 1'b1; ifu_rm_b.rready = 1'b1;
    lsu_rm_b.araddr = 32'h1000_0000; lsu_rm_b.arvalid = 1'b1; lsu_rm_b.rready = 1'b1;
    #1;
    n_checks++; if (lsu_rs_b.arready !== 1'b1) begin n_fail++; $display("FAIL fx1_lsu_arready: got %0h want 1", lsu_rs_b.arready); end
    n_checks++; if (ifu_rs_b.arready !== 1'b0) begin n_fail++; $display("FAIL fx1_ifu_arready: got %0h want 0", ifu_rs_b.arready); end
    @(negedge clock);
    lsu_rm_b.arvalid = 1'b0; imd_rs_b.arready = 1'b1;
    #1;
    n_checks++; if (imd_rm_b.araddr !== 32'h1000_0000) begin n_fail++; $display("FAIL fx1_araddr: got %h want 10000000", imd_rm_b.araddr); end
    @(negedge clock);
    imd_rs_b.arready = 1'b0; imd_rs_b.rvalid = 1'b1; imd_rs_b.rdata = 32'h4444_0004; imd_rs_b.rlast = 1'b1;
    #1;
    n_checks++; if (lsu_rs_b.rdata !== 32'h4444_0004 || lsu_rs_b.rvalid !== 1'b1) begin n_fail++; $display("FAIL fx1_lsu_data: got %h/%0h want 44440004/1", lsu_rs_b.rdata, lsu_rs_b.rvalid); end
    n_checks++; if (ifu_rs_b.rvalid !== 1'b0) begin n_fail++; $display("FAIL fx1_ifu_rvalid: got %0h want 0", ifu_rs_b.rvalid); end
    @(negedge clock);
    imd_rs_b.rvalid = 1'b0; imd_rs_b.rlast = 1'b0;
    lsu_rm_b.araddr = 32'h1000_0040; lsu_rm_b.arvalid = 1'b1;
    #1;
    n_checks++; if (lsu_rs_b.arready !== 1'b1) begin n_fail++; $display("FAIL fx2_lsu_arready: got %0h want 1", lsu_rs_b.arready); end
    n_checks++; if (ifu_rs_b.arready !== 1'b0) begin n_fail++; $display("FAIL fx2_ifu_arready: got %0h want 0", ifu_rs_b.arready); end
    @(negedge clock);
    lsu_rm_b.arvalid = 1'b0; imd_rs_b.arready = 1'b1;
    #1;
    n_checks++; if (imd_rm_b.araddr !== 32'h1000_0040) begin n_fail++; $display("FAIL fx2_araddr: got %h want 10000040", imd_rm_b.araddr); end
    @(negedge clock);
    imd_rs_b.arready = 1'b0; imd_rs_b.rvalid = 1'b1; imd_rs_b.rdata = 32'h5555_0005; imd_rs_b.rlast = 1'b1;
    #1;
    n_checks++; if (lsu_rs_b.rdata !== 32'h5555_0005 || lsu_rs_b.rvalid !== 1'b1) begin n_fail++; $display("FAIL fx2_lsu_data: got %h/%0h want 55550005/1", lsu_rs_b.rdata, lsu_rs_b.rvalid); end
    @(negedge clock);
    imd_rs_b.rvalid = 1'b0; imd_rs_b.rlast = 1'b0;
    #1;
    n_checks++; if (ifu_rs_b.arready !== 1'b1) begin n_fail++; $display("FAIL fx3_ifu_arready: got %0h want 1", ifu_rs_b.arready); end
    @(negedge clock);
    ifu_rm_b.arvalid = 1'b0; imd_rs_b.arready = 1'b1;
    #1;
    n_checks++; if (imd_rm_b.araddr !== 32'h8000_0010) begin n_fail++; $display("FAIL fx3_araddr: got %h want 80000010", imd_rm_b.araddr); end
    @(negedge clock);
    imd_rs_b.arready = 1'b0; imd_rs_b.rvalid = 1'b1; imd_rs_b.rdata = 32'h6666_0006; imd_rs_b.rlast = 1'b1;
    #1;
    n_checks++; if (ifu_rs_b.rdata !== 32'h6666_0006 || ifu_rs_b.rvalid !== 1'b1) begin n_fail++; $display("FAIL fx3_ifu_data: got %h/%0h want 66660006/1", ifu_rs_b.rdata, ifu_rs_b.rvalid); end
    @(negedge clock);
    imd_rs_b.rvalid = 1'b0; imd_rs_b.rlast = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    ifu_rm.araddr = 32'h8000_0300; ifu_rm.arlen = 8'd3; ifu_rm.arvalid = 1'b1; ifu_rm.rready = 1'b1;
    @(negedge clock);
    ifu_rm.arvalid = 1'b0; imd_rs.arready = 1'b1;
    @(negedge clock);
    imd_rs.arready = 1'b0; imd_rs.rvalid = 1'b1; imd_rs.rdata = 32'hC000_0000; imd_rs.rlast = 1'b0;
    #1;
    n_checks++; if (ifu_rs.rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_rvalid_before: got %0h want 1", ifu_rs.rvalid); end
    @(negedge clock);
    reset = 1'b1; imd_rs.rdata = 32'hC000_0001;
    @(negedge clock);
    #1;
    n_checks++; if (ifu_rs.rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_ifu_rvalid: got %0h want 0", ifu_rs.rvalid); end
    n_checks++; if (lsu_rs.rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_lsu_rvalid: got %0h want 0", lsu_rs.rvalid); end
    n_checks++; if (imd_rm.arvalid !== 1'b0) begin n_fail++; $display("FAIL mid_arvalid: got %0h want 0", imd_rm.arvalid); end
    n_checks++; if (imd_rm.rready !== 1'b0) begin n_fail++; $display("FAIL mid_rready: got %0h want 0", imd_rm.rready); end
    n_checks++; if (imd_rm.araddr !== 32'h0) begin n_fail++; $display("FAIL mid_araddr: got %h want 0", imd_rm.araddr); end
    reset = 1'b0; imd_rs.rvalid = 1'b0;
    @(negedge clock);
    ifu_rm.araddr = 32'h8000_0400; ifu_rm.arlen = 8'd0; ifu_rm.arvalid = 1'b1;
    #1;
    n_checks++; if (ifu_rs.arready !== 1'b1) begin n_fail++; $display("FAIL post_arready: got %0h want 1", ifu_rs.arready); end
    @(negedge clock);
    ifu_rm.arvalid = 1'b0; imd_rs.arready = 1'b1;
    #1;
    n_checks++; if (imd_rm.araddr !== 32'h8000_0400) begin n_fail++; $display("FAIL post_araddr: got %h want 80000400", imd_rm.araddr); end
    @(negedge clock);
    imd_rs.arready = 1'b0; imd_rs.rvalid = 1'b1; imd_rs.rdata = 32'h7777_0007; imd_rs.rlast = 1'b1;
    #1;
    n_checks++; if (ifu_rs.rdata !== 32'h7777_0007 || ifu_rs.rvalid !== 1'b1) begin n_fail++; $display("FAIL post_data: got %h/%0h want 77770007/1", ifu_rs.rdata, ifu_rs.rvalid); end
    @(negedge clock);
    imd_rs.rvalid = 1'b0; imd_rs.rlast = 1'b0;
    #1;
    n_checks++; if (ifu_rs.rvalid !== 1'b0) begin n_fail++; $display("FAIL post_idle_rvalid: got %0h want 0", ifu_rs.rvalid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_burst();
    test_rr_tie();
    test_rr_fixed();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_arbiter.md
# npc_arbiter

Two-master-to-one AXI arbiter sitting directly upstream of the sim crossbar. It merges the IFU read port and the LSU read/write ports onto the single `imd` master interface that the crossbar decodes by address. The crossbar routes the R and B channels using the live `araddr`/`awaddr`, so this block registers each granted address-channel beat and holds it stable on `imd` until the transaction's last response handshake completes.

## Interface
- `RR_EN`, default 1: 1 = round-robin on simultaneous read requests; 0 = LSU always wins.

- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `ifu_r_m2s`  in  `axi_r_m2s_t`  IFU read request and rready.
- `ifu_r_s2m`  out  `axi_r_s2m_t`  arready, rvalid, rdata, rlast to IFU.
- `lsu_r_m2s`  in  `axi_r_m2s_t`  LSU read request.
- `lsu_r_s2m`  out  `axi_r_s2m_t`  LSU read response.
- `lsu_w_m2s`  in  `axi_w_m2s_t`  LSU AW, W and bready.
- `lsu_w_s2m`  out  `axi_w_s2m_t`  LSU awready, wready, bvalid.
- `imd_r_m2s`  out  `axi_r_m2s_t`  merged read master to the crossbar.
- `imd_r_s2m`  in  `axi_r_s2m_t`  crossbar read response.
- `imd_w_m2s`  out  `axi_w_m2s_t`  write master to the crossbar.
- `imd_w_s2m`  in  `axi_w_s2m_t`  crossbar write response.

## Operation
- **Read FSM** `R_IDLE → R_AR → R_R → R_IDLE`.
  - `R_IDLE`: if any arvalid, choose a winner.
    - Tie with `RR_EN=1`: the master not in `last_grant` wins.
    - Tie with `RR_EN=0`: LSU wins.
    - Winner's arready = 1 combinationally. Loser's arready = 0.
    - Latch araddr, arlen, arsize, arburst and `grant`; go to `R_AR`.
  - `R_AR`: imd arvalid = 1 with the latched fields. On imd arready, go to `R_R`.
  - `R_R`:
    - imd rready = the granted master's rready.
    - Granted master receives imd rvalid, rdata, rlast.
    - Non-granted master sees rvalid = 0.
    - On rvalid & rready & rlast: set `last_grant` = `grant`; go to `R_IDLE`.
- **Write FSM** (LSU only) `W_IDLE → W_AW → W_W → W_B → W_IDLE`.
  - `W_IDLE`: lsu awready = 1. On lsu awvalid, latch awaddr, awlen, awsize, awburst; go to `W_AW`.
  - `W_AW`: imd awvalid = 1. On imd awready, go to `W_W`.
  - `W_W`:
    - wvalid, wdata, wstrb, wlast pass LSU → imd.
    - lsu wready = imd wready.
    - On a handshake with wlast, go to `W_B`.
  - `W_B`: imd bready = lsu bready; lsu bvalid = imd bvalid. On handshake, go to `W_IDLE`.
- Outside `W_W`: imd wvalid = 0 and lsu wready = 0, even if the LSU presents W early.
- Read and write FSMs run independently. The LSU issues at most one outstanding transaction, so no RAW ordering logic is needed.
- Latched address fields drive `imd` in every state. In idle they keep their last value.
- **Reset:**
  - FSMs go to their idle states; `last_grant` = LSU, so the IFU wins the first tie.
  - All latched fields = 0.
  - Every valid/ready output = 0, except the idle-state arready/awready, which follow the rules above.
- **Reset mid-transaction:** FSMs abort to idle in the next cycle. No response is forwarded afterwards.

## Timing
- AR accepted upstream in cycle N → imd arvalid in N+1.
  - Minimum read overhead is 1 cycle, plus a 1-cycle return to `R_IDLE` after rlast.
- AW accepted in N → imd awvalid in N+1.
- R/W/B data paths are combinational pass-through with zero added latency.
- Back-to-back reads: a new AR can be accepted no earlier than the cycle after the rlast handshake.
- Every AXI rule holds: valid never depends combinationally on ready on the `imd` side, and latched fields are stable while a valid is pending.

## Structure
- The FSM state enums (`rd_arb_state_e`, `wr_arb_state_e`) and a grant enum (`GNT_IFU`, `GNT_LSU`) go in `ysyx_24080006_pkg`, next to the existing AXI channel structs.
- One sub-module, `npc_arb_rr2`: a 2-input round-robin picker with `last_grant` state and the `RR_EN` parameter, instantiated by the read FSM.

## Test plan
- **IFU-only read:** IFU araddr 0x8000_0000, arlen 0. Expect:
  - imd arvalid one cycle after IFU arready.
  - rdata 0xDEAD_BEEF reaches the IFU.
  - LSU rvalid stays 0.
  - imd araddr holds 0x8000_0000 until rlast.
- **Simultaneous reads after reset, `RR_EN=1`:** IFU 0x8000_0010, LSU 0x1000_0000. Expect IFU served first, then LSU. Swap the order and repeat to confirm alternation.
- **Same stimulus with `RR_EN=0`:** LSU served first both times.
- **LSU write, awaddr 0x0200_0000, W asserted early:**
  - wready held 0 until `W_W`.
  - imd awaddr stable through the bvalid handshake.
  - B delivered to the LSU.
- **Burst read, arlen 3, with rready toggling:** 4 beats in order, rlast only on beat 4, then return to `R_IDLE`.
- **Reset asserted in `R_R` mid-burst:** next cycle all valids = 0, FSM idle. A subsequent read completes normally.
